cdb_arbiter: RTL and testbench

- Parametrised common-data-bus arbiter for the Tomasulo core. Replaces the fixed two-producer packed CDB (ALU + LSB) with NUM_SRC producers and NUM_LANE broadcast lanes.
- Each producer pushes {tag, data} results into its own small FIFO.
- Each cycle a rotating round-robin scan grants up to NUM_LANE FIFO heads, which are broadcast on registered lanes to the ROB, RS, LSB and branch predictor.

---
 rtl/cdb_arbiter_pkg.sv | 18 +
 rtl/cdb_src_fifo.sv | 65 ++++++
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths and
// helpers locating entry and lane fields inside packed vectors.
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W_DEF  = 4;
  localparam int CDB_DATA_W_DEF = 32;

  // FIFO entries are stored as {tag, data}.
  function automatic int entry_w(input int tag_w, input int data_w);
    return tag_w + data_w;
  endfunction

  // LSB of field 'idx' of width 'w' inside a packed per-lane or per-source bus.
  function automatic int field_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO with flush, global-ready gating and registered
// occupancy; the head entry is presented combinationally on rdata.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Fullness comes from the registered count, so a full FIFO never accepts
  // a push on the edge it pops.
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_push = rdy & ~flush & push & ~full;
  assign do_pop  = rdy & ~flush & pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (do_push) wr_q <= ptr_inc(wr_q);
        if (do_pop)  rd_q <= ptr_inc(rd_q);
        if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
        else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: NUM_SRC producer FIFOs, a rotating round-robin scan
// granting up to NUM_LANE heads per cycle, and registered broadcast lanes.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int NUM_LANE   = 2,
  parameter int DATA_W     = CDB_DATA_W_DEF,
  parameter int TAG_W      = CDB_TAG_W_DEF,
  parameter int FIFO_DEPTH = 2,
  localparam int SRC_W     = $clog2(NUM_SRC),
  localparam int ENTRY_W   = entry_w(TAG_W, DATA_W),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [NUM_LANE-1:0]        lane_valid,
  output logic [NUM_LANE*TAG_W-1:0]  lane_tag,
  output logic [NUM_LANE*DATA_W-1:0] lane_data,
  output logic [NUM_LANE*SRC_W-1:0]  lane_src,
  output logic [31:0]                stall_cnt
);

  logic [ENTRY_W-1:0] head     [NUM_SRC];
  logic [CNT_W-1:0]   count    [NUM_SRC];
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_LANE-1:0] lane_gnt;
  logic [SRC_W-1:0]   lane_sel [NUM_LANE];
  logic [SRC_W-1:0]   rr_q;
  logic [SRC_W-1:0]   rr_d;
  logic               lane_valid_q [NUM_LANE];
  logic [TAG_W-1:0]   lane_tag_q   [NUM_LANE];
  logic [DATA_W-1:0]  lane_data_q  [NUM_LANE];
  logic [SRC_W-1:0]   lane_src_q   [NUM_LANE];
  logic [31:0]        stall_q;
  logic               stall_any;

  assign src_ready = ~full & {NUM_SRC{rdy}};
  assign stall_any = |(src_valid & ~src_ready);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .push  (src_valid[gi] & src_ready[gi]),
      .pop   (grant[gi] & ~empty[gi]),
      .wdata ({src_tag[field_lsb(gi, TAG_W) +: TAG_W],
               src_data[field_lsb(gi, DATA_W) +: DATA_W]}),
      .rdata (head[gi]),
      .full  (full[gi]),
      .empty (empty[gi]),
      .count (count[gi])
    );
  end

  // Scan from rr_q; each non-empty source claims the next free lane.
  always_comb begin
    int n;
    int idx;
    grant    = '0;
    lane_gnt = '0;
    rr_d     = rr_q;
    n        = 0;
    idx      = 0;
    for (int l = 0; l < NUM_LANE; l++) lane_sel[l] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (count[idx] != '0 && n < NUM_LANE) begin
        grant[idx]  = 1'b1;
        lane_gnt[n] = 1'b1;
        lane_sel[n] = SRC_W'(idx);
        rr_d        = (idx == NUM_SRC - 1) ? '0 : SRC_W'(idx + 1);
        n           = n + 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= '0;
      stall_q <= '0;
      for (int l = 0; l < NUM_LANE; l++) begin
        lane_valid_q[l] <= 1'b0;
        lane_tag_q[l]   <= '0;
        lane_data_q[l]  <= '0;
        lane_src_q[l]   <= '0;
      end
    end else if (rdy) begin
      if (stall_any && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (flush) begin
        rr_q <= '0;
        for (int l = 0; l < NUM_LANE; l++) lane_valid_q[l] <= 1'b0;
      end else begin
        rr_q <= rr_d;
        // Ungranted lanes drop valid but keep their last tag/data/source.
        for (int l = 0; l < NUM_LANE; l++) begin
          lane_valid_q[l] <= lane_gnt[l];
          if (lane_gnt[l]) begin
            lane_tag_q[l]  <= head[lane_sel[l]][ENTRY_W-1 -: TAG_W];
            lane_data_q[l] <= head[lane_sel[l]][DATA_W-1:0];
            lane_src_q[l]  <= lane_sel[l];
          end
        end
      end
    end
  end

  assign stall_cnt = stall_q;

  for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_lane
    assign lane_valid[gi]                             = lane_valid_q[gi];
    assign lane_tag[field_lsb(gi, TAG_W) +: TAG_W]    = lane_tag_q[gi];
    assign lane_data[field_lsb(gi, DATA_W) +: DATA_W] = lane_data_q[gi];
    assign lane_src[field_lsb(gi, SRC_W) +: SRC_W]    = lane_src_q[gi];
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int L  = 2;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int D  = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          flush = 1'b0;
  logic [N-1:0]  src_valid = '0;
  logic [N-1:0]  src_ready;
  logic [N*TW-1:0] src_tag = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [L-1:0]  lane_valid;
  logic [L*TW-1:0] lane_tag;
  logic [L*DW-1:0] lane_data;
  logic [L*SW-1:0] lane_src;
  logic [31:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_SRC(N), .NUM_LANE(L), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_tag    (src_tag),
    .src_data   (src_data),
    .lane_valid (lane_valid),
    .lane_tag   (lane_tag),
    .lane_data  (lane_data),
    .lane_src   (lane_src),
    .stall_cnt  (stall_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one queue of {tag,data} per source, plus lane contents.
  logic [TW+DW-1:0] mq [N][$];
  logic           m_valid [L] = '{default: 1'b0};
  logic [TW-1:0]  m_tag   [L] = '{default: '0};
  logic [DW-1:0]  m_data  [L] = '{default: '0};
  int             m_src   [L] = '{default: 0};
  int             m_rr = 0;
  logic [31:0]    m_stall = '0;

  always @(posedge clk or posedge rst) begin
    bit ready_pre [N];
    bit any_stall;
    int n;
    int last;
    int idx;
    logic [TW+DW-1:0] e;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      for (int l = 0; l < L; l++) begin
        m_valid[l] = 1'b0; m_tag[l] = '0; m_data[l] = '0; m_src[l] = 0;
      end
      m_rr = 0;
      m_stall = '0;
    end else if (rdy) begin
      any_stall = 1'b0;
      for (int i = 0; i < N; i++) begin
        ready_pre[i] = (mq[i].size() < D);
        if (src_valid[i] && !ready_pre[i]) any_stall = 1'b1;
      end
      if (any_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        for (int l = 0; l < L; l++) m_valid[l] = 1'b0;
        m_rr = 0;
      end else begin
        n = 0;
        last = -1;
        for (int l = 0; l < L; l++) m_valid[l] = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (mq[idx].size() > 0 && n < L) begin
            e = mq[idx].pop_front();
            m_valid[n] = 1'b1;
            m_tag[n]   = e[TW+DW-1:DW];
            m_data[n]  = e[DW-1:0];
            m_src[n]   = idx;
            n++;
            last = idx;
          end
        end
        if (last >= 0) m_rr = (last + 1) % N;
        for (int i = 0; i < N; i++)
          if (src_valid[i] && ready_pre[i])
            mq[i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
      end
    end
    #1;
    for (int l = 0; l < L; l++) begin
      chk($sformatf("m_lane%0d_valid", l), 64'(lane_valid[l]), 64'(m_valid[l]));
      chk($sformatf("m_lane%0d_tag", l), 64'(lane_tag[l*TW +: TW]), 64'(m_tag[l]));
      chk($sformatf("m_lane%0d_data", l), 64'(lane_data[l*DW +: DW]), 64'(m_data[l]));
      chk($sformatf("m_lane%0d_src", l), 64'(lane_src[l*SW +: SW]), 64'(m_src[l]));
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("m_src_ready%0d", i), 64'(src_ready[i]), 64'((mq[i].size() < D) && rdy));
    chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int s, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_valid[s] = 1'b1;
    src_tag[s*TW +: TW] = t;
    src_data[s*DW +: DW] = d;
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_valid", 64'(lane_valid), 64'd0);
    chk("reset_tag", 64'(lane_tag), 64'd0);
    chk("reset_stall", 64'(stall_cnt), 64'd0);
    chk("reset_ready", 64'(src_ready), 64'hF);

    // Single uncontended push from source 2.
    put(2, 4'd5, 32'hDEAD_BEEF);
    step();
    src_valid = '0;
    chk("single_edge0_valid", 64'(lane_valid), 64'd0);
    step();
    chk("single_valid", 64'(lane_valid), 64'b01);
    chk("single_tag", 64'(lane_tag[3:0]), 64'd5);
    chk("single_data", 64'(lane_data[31:0]), 64'hDEAD_BEEF);
    chk("single_src", 64'(lane_src[1:0]), 64'd2);
    step();
    chk("single_after", 64'(lane_valid), 64'd0);

    flush = 1'b1;
    step();
    flush = 1'b0;

    // Contention: four sources at once, rr pointer at 0.
    for (int i = 0; i < N; i++) put(i, 4'(i + 1), 32'(100 + i));
    step();
    src_valid = '0;
    step();
    chk("cont1_valid", 64'(lane_valid), 64'b11);
    chk("cont1_tags", 64'(lane_tag), 64'h21);
    chk("cont1_srcs", 64'(lane_src), 64'b0100);
    step();
    chk("cont2_tags", 64'(lane_tag), 64'h43);
    chk("cont2_srcs", 64'(lane_src), 64'b1110);
    step();
    chk("cont3_valid", 64'(lane_valid), 64'd0);

    // rr pointer back at 0: source 0 must take lane 0 ahead of source 3.
    put(3, 4'd9, 32'h9);
    put(0, 4'd6, 32'h6);
    step();
    src_valid = '0;
    step();
    chk("rr_srcs", 64'(lane_src), 64'b1100);
    chk("rr_tags", 64'(lane_tag), 64'h96);

    // Flush with three queued entries and a simultaneous push from source 3.
    put(0, 4'hA, 32'hA); put(1, 4'hB, 32'hB); put(2, 4'hC, 32'hC);
    step();
    src_valid = '0;
    flush = 1'b1;
    put(3, 4'hD, 32'hD);
    step();
    flush = 1'b0;
    src_valid = '0;
    chk("flush_valid", 64'(lane_valid), 64'd0);
    chk("flush_ready", 64'(src_ready), 64'hF);
    step();
    chk("flush_valid2", 64'(lane_valid), 64'd0);
    step();
    chk("flush_valid3", 64'(lane_valid), 64'd0);

    // rdy freeze with pending entries.
    for (int i = 0; i < N; i++) put(i, 4'(8 + i), 32'(200 + i));
    step();
    src_valid = '0;
    rdy = 1'b0;
    src_valid[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("freeze_ready", 64'(src_ready), 64'd0);
      chk("freeze_valid", 64'(lane_valid), 64'd0);
      chk("freeze_stall", 64'(stall_cnt), 64'd0);
    end
    rdy = 1'b1;
    src_valid = '0;
    step();
    chk("thaw1_tags", 64'(lane_tag), 64'h98);
    chk("thaw1_valid", 64'(lane_valid), 64'b11);
    step();
    chk("thaw2_tags", 64'(lane_tag), 64'hBA);
    step();

    // Backpressure: every source pushes every cycle.
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) put(i, 4'(c + i), 32'(c * 16 + i));
      step();
      if (c == 2) chk("bp_ready_e3", 64'(src_ready), 64'b1100);
      if (c == 3) chk("bp_ready_e4", 64'(src_ready), 64'b0011);
    end
    src_valid = '0;
    chk("bp_stall", 64'(stall_cnt), 64'd8);

    // Asynchronous reset between edges while FIFOs still hold entries.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(lane_valid), 64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst_ready", 64'(src_ready), 64'hF);
    chk("arst_valid2", 64'(lane_valid), 64'd0);

    // Mixed traffic checked by the model alone.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) put(i, 4'($urandom), $urandom);
      src_valid = 4'($urandom);
      rdy = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    src_valid = '0;
    rdy = 1'b1;
    flush = 1'b0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
